// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the frame FIFO write-side scheduler.
// The optional conversion watchdog is enabled by defining CONV_TIMEOUT_EN.
package fifo_sched_pkg;

    localparam int NUM_CH_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int CH_W_DEF   = 3;
    localparam int DROP_W_DEF = 8;

    // Wait cycles in CONV before the watchdog substitutes TIMEOUT_WORD
    localparam int          TIMEOUT_CYC  = 1024;
    localparam logic [15:0] TIMEOUT_WORD = 16'hDEAD;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } sched_state_t;

endpackage

// File: rtl/ch_next_finder.sv
// Combinational channel search over a slot mask: lowest set bit overall
// (frame start) and lowest set bit strictly above the current channel.
module ch_next_finder #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 3
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   ch,
    output logic [CH_W-1:0]   first_idx,
    output logic [CH_W-1:0]   next_idx,
    output logic              has_next
);

    logic [NUM_CH-1:0] above;

    // Slots that are enabled and sit above the current channel
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_above
            assign above[gi] = mask[gi] && (CH_W'(gi) > ch);
        end
    endgenerate

    // Priority encode from the top down so the lowest index wins
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        has_next  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_idx = CH_W'(i);
            end
            if (above[i]) begin
                next_idx = CH_W'(i);
                has_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_frame_scheduler.sv
// Write-side frame sequencer for the dual-clock frame FIFO (sample_clk domain).
// Walks enabled channels in ascending order, requests one conversion per
// channel and writes each result to the FIFO. Whole frames are dropped and
// counted when the FIFO is full at frame start.
// Optional: define CONV_TIMEOUT_EN to add a conversion watchdog and the
// err_timeout output.
module fifo_frame_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CH_W   = CH_W_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic              sample_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              frame_trigger,
    output logic              conv_start,
    input  logic              conv_ready,
    input  logic [DATA_W-1:0] conv_data,
    input  logic              fifo_full,
    output logic [DATA_W-1:0] data_in,
    output logic              done,
    output logic              last_word,
    output logic [CH_W-1:0]   atmchsel,
    output logic              busy,
    output logic              err_overrun,
`ifdef CONV_TIMEOUT_EN
    output logic              err_timeout,
`endif
    output logic [DROP_W-1:0] drop_cnt
);

    sched_state_t      state_reg;
    logic [NUM_CH-1:0] mask_reg;
    logic [CH_W-1:0]   ch_reg;

    logic [NUM_CH-1:0] search_mask;
    logic [CH_W-1:0]   first_idx;
    logic [CH_W-1:0]   next_idx;
    logic              has_next;

    logic              conv_evt;
    logic [DATA_W-1:0] conv_word;

    // At frame start search the live mask; mid-frame use the latched copy
    assign search_mask = (state_reg == IDLE) ? ch_mask : mask_reg;

    ch_next_finder #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_finder (
        .mask      (search_mask),
        .ch        (ch_reg),
        .first_idx (first_idx),
        .next_idx  (next_idx),
        .has_next  (has_next)
    );

`ifdef CONV_TIMEOUT_EN
    logic [15:0] wd_cnt_reg;
    logic        wd_fire;

    assign wd_fire   = (state_reg == CONV) && !conv_ready &&
                       (wd_cnt_reg == 16'(TIMEOUT_CYC - 1));
    assign conv_evt  = conv_ready | wd_fire;
    assign conv_word = conv_ready ? conv_data : DATA_W'(TIMEOUT_WORD);

    // Watchdog: counts wait cycles for the current conversion only
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_reg <= '0;
        end else if (state_reg != CONV || conv_evt) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_reg + 16'd1;
        end
    end

    // Sticky timeout flag, cleared like err_overrun (disabled while idle)
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout <= 1'b0;
        end else if (wd_fire) begin
            err_timeout <= 1'b1;
        end else if (state_reg == IDLE && !enable) begin
            err_timeout <= 1'b0;
        end
    end
`else
    assign conv_evt  = conv_ready;
    assign conv_word = conv_data;
`endif

    // Frame sequencer with registered FIFO-side and ADC-side outputs
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            mask_reg    <= '0;
            ch_reg      <= '0;
            conv_start  <= 1'b0;
            data_in     <= '0;
            done        <= 1'b0;
            last_word   <= 1'b0;
            atmchsel    <= '0;
            busy        <= 1'b0;
            err_overrun <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            conv_start <= 1'b0;
            done       <= 1'b0;
            last_word  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!enable) begin
                        err_overrun <= 1'b0;
                    end
                    if (frame_trigger && enable && (|ch_mask)) begin
                        if (fifo_full) begin
                            // Whole frame dropped; counter sticks at all-ones
                            if (drop_cnt != '1) begin
                                drop_cnt <= drop_cnt + 1'b1;
                            end
                        end else begin
                            mask_reg   <= ch_mask;
                            ch_reg     <= first_idx;
                            state_reg  <= CONV;
                            conv_start <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                end
                CONV: begin
                    // busy is still high here, so a trigger coinciding with
                    // the final conversion is also an overrun
                    if (frame_trigger) begin
                        err_overrun <= 1'b1;
                    end
                    if (conv_evt) begin
                        data_in   <= conv_word;
                        atmchsel  <= ch_reg;
                        done      <= 1'b1;
                        last_word <= !has_next;
                        if (has_next) begin
                            ch_reg     <= next_idx;
                            conv_start <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_frame_scheduler.sv
// Scoreboard bench for fifo_frame_scheduler: stimulus pushes expected FIFO
// writes, a monitor pops and compares on every done strobe.
module tb_fifo_frame_scheduler;

    logic        sample_clk;
    logic        reset_n;
    logic        enable;
    logic [7:0]  ch_mask;
    logic        frame_trigger;
    logic        conv_start;
    logic        conv_ready;
    logic [15:0] conv_data;
    logic        fifo_full;
    logic [15:0] data_in;
    logic        done;
    logic        last_word;
    logic [2:0]  atmchsel;
    logic        busy;
    logic        err_overrun;
    logic [7:0]  drop_cnt;
`ifdef CONV_TIMEOUT_EN
    logic        err_timeout;
`endif

    fifo_frame_scheduler dut (
        .sample_clk    (sample_clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .ch_mask       (ch_mask),
        .frame_trigger (frame_trigger),
        .conv_start    (conv_start),
        .conv_ready    (conv_ready),
        .conv_data     (conv_data),
        .fifo_full     (fifo_full),
        .data_in       (data_in),
        .done          (done),
        .last_word     (last_word),
        .atmchsel      (atmchsel),
        .busy          (busy),
        .err_overrun   (err_overrun),
`ifdef CONV_TIMEOUT_EN
        .err_timeout   (err_timeout),
`endif
        .drop_cnt      (drop_cnt)
    );

    typedef struct {
        logic [15:0] data;
        logic [2:0]  ch;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] adc_q[$];

    int checks    = 0;
    int errors    = 0;
    int start_cnt = 0;
    int run_len   = 0;
    int max_run   = 0;
    int adc_mode  = 1;   // 0: silent, 1: reply 3 cycles after conv_start, 2: ready held high
    int adc_cnt   = 0;
    bit trig_on_last = 0;
    bit trig_set     = 0;

    initial sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Expected FIFO writes for a frame: data = ch * 0x0101, last on top slot
    task automatic push_frame(input logic [7:0] m);
        int   top;
        exp_t e;
        top = -1;
        for (int i = 0; i < 8; i++) if (m[i]) top = i;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                e.data = 16'(i) * 16'h0101;
                e.ch   = 3'(i);
                e.last = (i == top);
                sb.push_back(e);
                adc_q.push_back(e.data);
            end
        end
    endtask

    task automatic trig();
        @(negedge sample_clk);
        frame_trigger = 1'b1;
        @(negedge sample_clk);
        frame_trigger = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge sample_clk);
            if (!busy) break;
        end
        chk("idle_within_budget", 32'(busy), 32'd0);
    endtask

    // ADC front-end model
    initial begin
        conv_ready = 1'b0;
        conv_data  = 16'h0000;
        forever begin
            @(negedge sample_clk);
            if (trig_set) begin
                frame_trigger = 1'b0;
                trig_set = 0;
            end
            if (adc_mode == 2) begin
                conv_ready = 1'b1;
                conv_data  = 16'h5A5A;
            end else begin
                conv_ready = 1'b0;
                if (adc_cnt > 0) begin
                    adc_cnt--;
                    if (adc_cnt == 0) begin
                        conv_ready = 1'b1;
                        conv_data  = (adc_q.size() > 0) ? adc_q.pop_front() : 16'hBAD0;
                        if (trig_on_last && adc_q.size() == 0) begin
                            frame_trigger = 1'b1;
                            trig_set = 1;
                        end
                    end
                end
                if (adc_mode == 1 && conv_start) adc_cnt = 3;
            end
        end
    end

    // Monitor: compares every FIFO write against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge sample_clk);
            #1;
            if (conv_start) start_cnt++;
            if (done) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got atmchsel=%0d data=%0h expected no write", atmchsel, data_in);
                end else begin
                    e = sb.pop_front();
                    chk("wr_data", 32'(data_in), 32'(e.data));
                    chk("wr_atmchsel", 32'(atmchsel), 32'(e.ch));
                    chk("wr_last_word", 32'(last_word), 32'(e.last));
                    chk("busy_at_write", 32'(busy), 32'(!e.last));
                    chk("conv_start_with_write", 32'(conv_start), 32'(!e.last));
                end
            end else begin
                run_len = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b1;
        ch_mask       = 8'h00;
        frame_trigger = 1'b0;
        fifo_full     = 1'b0;

        // Reset state
        repeat (3) @(negedge sample_clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_conv_start", 32'(conv_start), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_err_overrun", 32'(err_overrun), 32'd0);
        reset_n = 1'b1;
        @(negedge sample_clk);

        // Full mask, ADC replies 3 cycles after each request
        ch_mask = 8'hFF; adc_mode = 1; start_cnt = 0;
        push_frame(8'hFF);
        trig();
        wait_idle(200);
        repeat (3) @(negedge sample_clk);
        chk("ff_conv_starts", 32'(start_cnt), 32'd8);
        chk("ff_sb_drained", 32'(sb.size()), 32'd0);

        // Sparse mask 1010_0100 -> slots 2,5,7
        ch_mask = 8'hA4; start_cnt = 0;
        push_frame(8'hA4);
        trig();
        wait_idle(200);
        repeat (3) @(negedge sample_clk);
        chk("a4_conv_starts", 32'(start_cnt), 32'd3);
        chk("a4_sb_drained", 32'(sb.size()), 32'd0);

        // conv_ready held high: 8 back-to-back writes
        ch_mask = 8'hFF; adc_mode = 2; max_run = 0;
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.data = 16'h5A5A; e.ch = 3'(i); e.last = (i == 7);
            sb.push_back(e);
        end
        trig();
        wait_idle(200);
        repeat (4) @(negedge sample_clk);
        adc_mode = 0;
        @(negedge sample_clk);
        chk("cont_run_length", 32'(max_run), 32'd8);
        chk("cont_sb_drained", 32'(sb.size()), 32'd0);

        // Ignored triggers: enable low, then empty mask (FIFO full both times)
        adc_mode = 1; fifo_full = 1'b1; start_cnt = 0;
        enable = 1'b0; ch_mask = 8'hFF;
        trig();
        enable = 1'b1; ch_mask = 8'h00;
        trig();
        repeat (3) @(negedge sample_clk);
        chk("ign_conv_starts", 32'(start_cnt), 32'd0);
        chk("ign_drop_cnt", 32'(drop_cnt), 32'd0);

        // Drops while FIFO full, saturating at 255
        ch_mask = 8'hFF;
        trig();
        @(negedge sample_clk);
        chk("drop_first", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 299; i++) trig();
        @(negedge sample_clk);
        chk("drop_saturated", 32'(drop_cnt), 32'd255);
        chk("drop_conv_starts", 32'(start_cnt), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        fifo_full = 1'b0; ch_mask = 8'h81;
        push_frame(8'h81);
        trig();
        wait_idle(200);
        repeat (3) @(negedge sample_clk);
        chk("post_drop_conv_starts", 32'(start_cnt), 32'd2);
        chk("post_drop_sb_drained", 32'(sb.size()), 32'd0);

        // Trigger during a frame
        ch_mask = 8'h12; start_cnt = 0;
        push_frame(8'h12);
        trig();
        repeat (2) @(negedge sample_clk);
        frame_trigger = 1'b1;
        @(negedge sample_clk);
        frame_trigger = 1'b0;
        ch_mask = 8'hFF;   // mid-frame mask change must not matter
        wait_idle(200);
        repeat (3) @(negedge sample_clk);
        chk("ovr_mid_flag", 32'(err_overrun), 32'd1);
        chk("ovr_mid_conv_starts", 32'(start_cnt), 32'd2);
        chk("ovr_mid_drop_cnt", 32'(drop_cnt), 32'd255);
        chk("ovr_mid_sb_drained", 32'(sb.size()), 32'd0);
        enable = 1'b0;
        @(negedge sample_clk);
        enable = 1'b1;
        chk("ovr_clear", 32'(err_overrun), 32'd0);

        // Trigger coincident with the final conversion
        ch_mask = 8'h12; start_cnt = 0; trig_on_last = 1;
        push_frame(8'h12);
        trig();
        wait_idle(200);
        repeat (4) @(negedge sample_clk);
        trig_on_last = 0;
        chk("ovr_last_flag", 32'(err_overrun), 32'd1);
        chk("ovr_last_conv_starts", 32'(start_cnt), 32'd2);
        chk("ovr_last_busy", 32'(busy), 32'd0);
        chk("ovr_last_sb_drained", 32'(sb.size()), 32'd0);

`ifdef CONV_TIMEOUT_EN
        // Silent ADC: watchdog writes TIMEOUT_WORD
        enable = 1'b0;
        @(negedge sample_clk);
        enable = 1'b1;
        adc_mode = 0; ch_mask = 8'h01;
        begin
            exp_t e;
            e.data = 16'hDEAD; e.ch = 3'd0; e.last = 1'b1;
            sb.push_back(e);
        end
        trig();
        wait_idle(1200);
        @(negedge sample_clk);
        chk("timeout_flag", 32'(err_timeout), 32'd1);
        chk("timeout_sb_drained", 32'(sb.size()), 32'd0);
`endif

        // Asynchronous reset in the middle of a conversion wait
        adc_mode = 0; ch_mask = 8'h30;
        trig();
        repeat (3) @(negedge sample_clk);
        chk("mid_conv_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("arst_err_overrun", 32'(err_overrun), 32'd0);
        chk("arst_data_in", 32'(data_in), 32'd0);
        chk("arst_atmchsel", 32'(atmchsel), 32'd0);
        chk("arst_done_last", 32'({done, last_word, conv_start}), 32'd0);
        @(negedge sample_clk);
        reset_n = 1'b1;
        @(negedge sample_clk);
        adc_mode = 1; start_cnt = 0;
        push_frame(8'h30);
        trig();
        wait_idle(200);
        repeat (3) @(negedge sample_clk);
        chk("post_rst_conv_starts", 32'(start_cnt), 32'd2);
        chk("post_rst_sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_frame_scheduler.md
Name: fifo_frame_scheduler

Overview:
Write-side sequencer for the dual-clock frame FIFO, running in the sample_clk domain. On each frame trigger it steps through the enabled ADC channels in ascending order. For each channel it requests a conversion, then presents the result to the FIFO write port (data_in/done/atmchsel/last_word). It drops whole frames when the FIFO reports full and counts the drops.

Parameters:
NUM_CH, 8, number of channel slots per frame (one 16-bit word each)
DATA_W, 16, conversion/FIFO word width
CH_W, 3, channel index width (clog2 NUM_CH)
DROP_W, 8, width of saturating dropped-frame counter

Ports:
sample_clk  input  1  block clock (FIFO write clock)
reset_n  input  1  asynchronous active-low reset
enable  input  1  scheduler enable; sampled at frame start only
ch_mask  input  NUM_CH  channel enable mask; latched at frame start
frame_trigger  input  1  one-cycle start-of-frame strobe
conv_start  output  1  one-cycle conversion request to ADC front end
conv_ready  input  1  one-cycle strobe: conv_data valid
conv_data  input  DATA_W  conversion result
fifo_full  input  1  FIFO cannot accept another frame
data_in  output  DATA_W  word to FIFO
done  output  1  one-cycle write strobe to FIFO
last_word  output  1  qualifies done; final word of frame
atmchsel  output  CH_W  slot index of word within frame
busy  output  1  frame in progress
err_overrun  output  1  sticky: trigger arrived while busy
drop_cnt  output  DROP_W  saturating count of frames dropped on fifo_full

Behaviour:
- Reset: every output is 0. State = IDLE. Internal mask_q and ch are 0. Reset mid-frame aborts immediately; no partial done is emitted afterwards.
- All outputs are registered.
- States:
  - IDLE:
    - Trigger condition: frame_trigger & enable & |ch_mask.
    - Trigger condition with fifo_full=1: drop_cnt += 1, saturating at all-ones. Stay in IDLE.
    - Trigger condition with fifo_full=0: mask_q <= ch_mask; ch <= lowest set bit; go to CONV. conv_start=1 in the first CONV cycle; busy=1 from that cycle.
    - Trigger with enable=0 or ch_mask=0: ignored; no counter change.
  - CONV:
    - Hold until conv_ready=1. On conv_ready, the next cycle drives:
      - data_in <= conv_data;
      - atmchsel <= ch;
      - done <= 1 for exactly 1 cycle;
      - last_word <= 1 if mask_q has no set bit above ch.
    - If last: go to IDLE. busy drops in the same cycle done/last_word assert.
    - Otherwise: ch <= next set bit above ch; stay in CONV. conv_start re-pulses in the same cycle as done, which allows back-to-back conversions.
    - conv_ready while not waiting (IDLE) is ignored.
- Latency: trigger to first conv_start = 1 cycle. conv_ready to done = 1 cycle.
- atmchsel carries the physical channel index, not a packed position. Unmasked slots are never written (the FIFO zero-fills them).
- fifo_full is checked only at frame start. An accepted frame always completes.
- frame_trigger while busy:
  - The trigger is discarded and err_overrun sets.
  - err_overrun clears only when enable=0 in IDLE, or on reset.
  - drop_cnt is unchanged.
- Mid-frame changes:
  - enable falling: the current frame completes.
  - ch_mask changes: ignored until the next frame.
- Simultaneous frame_trigger and last conv_ready: the trigger counts as an overrun (busy still 1 that cycle).

Optional Feature:
CONV_TIMEOUT_EN:
- Defined: a 16-bit watchdog counts CONV wait cycles.
  - Reaching TIMEOUT_CYC (package constant, 1024) behaves as if conv_ready arrived with conv_data = 16'hDEAD.
  - Sticky output err_timeout (port present only when defined) sets; it clears under the same rule as err_overrun.
- Undefined: CONV waits indefinitely and there is no err_timeout port.

Decomposition:
- Package fifo_sched_pkg:
  - state enum {IDLE, CONV};
  - NUM_CH/DATA_W/CH_W defaults;
  - TIMEOUT_CYC;
  - TIMEOUT_WORD = 16'hDEAD.
- Sub-module ch_next_finder (combinational): given mask_q and ch, returns first set bit (for frame start) or next set bit above ch, plus a has_next flag used for last_word.

Test Plan:
- ch_mask=8'hFF, conv_ready 3 cycles after each conv_start, data=ch*16'h0101 -> 8 done pulses, atmchsel 0..7, data 0000..0707, last_word only with atmchsel=7; busy low after.
- ch_mask=8'b1010_0100 -> done with atmchsel 2,5,7; last_word on 7; exactly 3 conv_start pulses.
- conv_ready held high continuously, mask=FF -> done on consecutive conv_ready-driven cycles, 8 words with no gaps, no duplicate atmchsel.
- fifo_full=1, 300 triggers -> no conv_start, drop_cnt saturates at 255; fifo_full=0 plus trigger -> normal frame.
- Trigger during frame and trigger coincident with last conv_ready -> err_overrun=1, frame output unchanged; enable=0 in IDLE -> clears.
- reset_n low mid-CONV -> all outputs 0 asynchronously. Next trigger after release starts at the lowest set bit. With CONV_TIMEOUT_EN and no conv_ready -> after 1024 cycles, done with data 16'hDEAD and err_timeout=1.
